at_resp_parser: RTL and testbench
=================================

Name: at_resp_parser

Overview:
- Receive-side companion to the SMS command FSM.
- Consumes the byte stream from the UART receiver and recognises modem response lines: OK, ERROR, +CMPS: and +CMTI:.
- Presents the result as the 3-bit `ctrl` code the SMS FSM polls. Captures the stored-message index as `msg_no`, which the FSM sends back after AT+CMGR=.
- `ctrl` holds its value until the FSM acknowledges it with `ctrl_rst`.

Parameters:
- MAX_LINE, 32, maximum characters per line before the remainder of the line is discarded (line-length overflow).
- IDX_DIGITS, 1, number of decimal digits accepted in the +CMTI index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte, valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe from the UART RX.
- ctrl_rst  in  1  acknowledge from the SMS FSM; clears ctrl to 000.
- ctrl  out  3  response code: 000 none, 001 OK, 010 +CMPS:, 011 ERROR or bad index, 100 +CMTI new message.
- msg_no  out  8  ASCII digit of the last valid +CMTI index.
- busy  out  1  high while a line is partially received.
- ovf_cnt  out  8  saturating count of overflowed lines.

Behaviour:
- Reset (rst=0, asynchronous): ctrl=000, msg_no=8'h30, busy=0, ovf_cnt=0, state=IDLE, position counter pos=0.
- Bytes are only acted on when rx_valid=1. All outputs are registered. ctrl/msg_no update on the clock edge that samples the deciding byte, so they are visible in the next cycle.
- States:
  - IDLE: LF (0x0A) and CR (0x0D) are ignored. Any other byte → MATCH with pos=1, busy=1, candidate mask initialised from the first byte.
  - MATCH: each byte is compared against the char at index pos of "OK", "ERROR", "+CMPS:" and "+CMTI:". Candidates that mismatch drop out of the mask; pos increments.
    - Mask empty → DISCARD.
    - "+CMPS:" fully matched → ctrl=010, then DISCARD; the rest of the line is ignored.
    - "+CMTI:" fully matched → ARG.
    - CR with exactly "OK" or "ERROR" matched (pos equals length) → ctrl=001 or 011 respectively, then IDLE.
    - CR otherwise → IDLE, no event.
  - ARG: skip bytes up to and including ','.
    - Next byte '0'..'9' → latched as candidate index, state IDX.
    - Non-digit → ctrl=011, DISCARD.
    - CR before a digit → ctrl=011, IDLE.
  - IDX:
    - CR with digit count ≤ IDX_DIGITS → msg_no = latched digit (last digit when IDX_DIGITS>1), ctrl=100, IDLE.
    - More digits than IDX_DIGITS, or a non-digit → ctrl=011, msg_no unchanged, DISCARD.
  - DISCARD: wait for CR → IDLE.
- Line-length overflow: when pos reaches MAX_LINE without a CR → DISCARD and ovf_cnt += 1, saturating at 255.
- busy: 1 in MATCH/ARG/IDX/DISCARD, 0 in IDLE.
- ctrl_rst: sets ctrl=000 on the next edge. When ctrl_rst and a new event occur in the same cycle, the event wins and ctrl takes the new code.
- A new event while ctrl≠000 overwrites ctrl (latest wins). msg_no changes only on a valid +CMTI.
- Matching is case-sensitive. A byte arriving on the same edge as an asynchronous reset assertion is dropped.

Optional Feature:
- Macro: AT_ECHO_FILTER_EN.
- Defined: a line whose first two characters are "AT" is the modem's command echo. It is forced to DISCARD with no event, is not counted in ovf_cnt, and a second cycle-counted status bit is not added.
- Undefined: echo lines go through normal matching. They never match any candidate and are discarded silently; behaviour on all other lines is identical.

Test Plan:
- Reset then bytes "\r\nOK\r" → ctrl=001 one cycle after the CR strobe; busy=1 from 'O' until the CR edge; ctrl_rst pulse → ctrl=000.
- "+CMTI: \"SM\",3\r" → ctrl=100, msg_no=8'h33; repeat with ",12\r" (IDX_DIGITS=1) → ctrl=011, msg_no stays 8'h33.
- "+CMPS: 10,30\r" → ctrl=010 on the edge sampling ':' (before the CR); trailing bytes produce no further change.
- "ERROR\r" arriving with ctrl_rst asserted in the cycle of its CR → ctrl=011, not 000. "OKAY\r" → no event.
- 40 'x' bytes then CR (MAX_LINE=32) → ovf_cnt=1, busy=1 until the CR, no ctrl change; the next "OK\r" parses normally.
- Drive rst low mid-line after "+CM" → all outputs return to reset values immediately; a following "OK\r" → ctrl=001. With AT_ECHO_FILTER_EN defined, "AT+CMGD=1,4\r" → no event, ovf_cnt unchanged.

Source files
------------

// File: rtl/at_resp_parser_if.sv
// Byte-stream and response-code bundle between the UART RX / SMS FSM side and
// the AT response parser.
interface at_resp_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ctrl_rst;
    logic [2:0] ctrl;
    logic [7:0] msg_no;
    logic       busy;
    logic [7:0] ovf_cnt;

    modport master (
        output rx_data, rx_valid, ctrl_rst,
        input  ctrl, msg_no, busy, ovf_cnt
    );

    modport slave (
        input  rx_data, rx_valid, ctrl_rst,
        output ctrl, msg_no, busy, ovf_cnt
    );
endinterface

// File: rtl/at_resp_parser.sv
// Modem response line parser: recognises OK, ERROR, +CMPS: and +CMTI:<idx>.
// Optional macro AT_ECHO_FILTER_EN drops "AT..." command-echo lines early.
module at_resp_parser #(
    parameter int MAX_LINE   = 32,
    parameter int IDX_DIGITS = 1
) (
    input logic             clk,
    input logic             rst,
    at_resp_parser_if.slave bus
);

    localparam int POS_W = $clog2(MAX_LINE + 1);
    localparam logic [POS_W-1:0] POS_ZERO     = POS_W'(32'd0);
    localparam logic [POS_W-1:0] POS_ONE      = POS_W'(32'd1);
    localparam logic [POS_W-1:0] POS_OK_LEN   = POS_W'(32'd2);
    localparam logic [POS_W-1:0] POS_ERR_LEN  = POS_W'(32'd5);
    localparam logic [POS_W-1:0] POS_TAG_LAST = POS_W'(32'd5);
    localparam logic [POS_W-1:0] POS_MAX      = POS_W'(MAX_LINE);
    localparam logic [7:0]       IDX_MAX      = 8'(IDX_DIGITS);

`ifdef AT_ECHO_FILTER_EN
    localparam logic ECHO_EN = 1'b1;
`else
    localparam logic ECHO_EN = 1'b0;
`endif

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    // Candidate strings, left-aligned in 48 bits so byte p sits at [47-8p -: 8]
    localparam logic [47:0] STR_OK   = {"OK", 32'h0000_0000};
    localparam logic [47:0] STR_ERR  = {"ERROR", 8'h00};
    localparam logic [47:0] STR_CMPS = "+CMPS:";
    localparam logic [47:0] STR_CMTI = "+CMTI:";

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_OK   = 3'd1;
    localparam logic [2:0] CODE_CMPS = 3'd2;
    localparam logic [2:0] CODE_ERR  = 3'd3;
    localparam logic [2:0] CODE_CMTI = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MATCH   = 3'd1,
        S_ARG     = 3'd2,
        S_IDX     = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    function automatic logic [47:0] cand_str(input logic [1:0] c);
        case (c)
            2'd0:    cand_str = STR_OK;
            2'd1:    cand_str = STR_ERR;
            2'd2:    cand_str = STR_CMPS;
            default: cand_str = STR_CMTI;
        endcase
    endfunction

    function automatic logic [2:0] cand_len(input logic [1:0] c);
        case (c)
            2'd0:    cand_len = 3'd2;
            2'd1:    cand_len = 3'd5;
            default: cand_len = 3'd6;
        endcase
    endfunction

    function automatic logic cand_hit(input logic [1:0] c, input logic alive,
                                      input logic [POS_W-1:0] p, input logic [7:0] b);
        logic [47:0] sh;
        sh = cand_str(c) << {p[2:0], 3'b000};
        if (p < POS_W'(cand_len(c))) begin
            cand_hit = alive && (b == sh[47:40]);
        end else begin
            cand_hit = 1'b0;
        end
    endfunction

    function automatic logic [3:0] step_mask(input logic [3:0] m, input logic [POS_W-1:0] p,
                                             input logic [7:0] b);
        step_mask = {cand_hit(2'd3, m[3], p, b), cand_hit(2'd2, m[2], p, b),
                     cand_hit(2'd1, m[1], p, b), cand_hit(2'd0, m[0], p, b)};
    endfunction

    state_t           state_r, state_s;
    logic [POS_W-1:0] pos_r, pos_s;
    logic [3:0]       mask_r, mask_s, nmask_s;
    logic             comma_r, comma_s;
    logic [7:0]       idx_r, idx_s;
    logic [7:0]       dig_cnt_r, dig_s;
    logic             echo_r, echo_s;
    logic [2:0]       ctrl_r, ctrl_s, code_s;
    logic [7:0]       msg_no_r, msg_s;
    logic             busy_r, busy_s;
    logic [7:0]       ovf_r, ovf_s;
    logic             ev_s, ovf_hit_s;
    logic             is_cr_s, is_dig_s;

    assign is_cr_s  = (bus.rx_data == CH_CR);
    assign is_dig_s = (bus.rx_data >= CH_0) && (bus.rx_data <= CH_9);

    // Next-state, event and output decode for the line FSM
    always_comb begin
        state_s   = state_r;
        pos_s     = pos_r;
        mask_s    = mask_r;
        comma_s   = comma_r;
        idx_s     = idx_r;
        dig_s     = dig_cnt_r;
        echo_s    = echo_r;
        ev_s      = 1'b0;
        code_s    = CODE_NONE;
        msg_s     = msg_no_r;
        ovf_hit_s = 1'b0;
        nmask_s   = step_mask(mask_r, pos_r, bus.rx_data);

        if (bus.rx_valid) begin
            case (state_r)
                S_IDLE: begin
                    if (is_cr_s || (bus.rx_data == CH_LF)) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_MATCH;
                        pos_s   = POS_ONE;
                        mask_s  = step_mask(4'b1111, POS_ZERO, bus.rx_data);
                        comma_s = 1'b0;
                        dig_s   = 8'd0;
                        echo_s  = ECHO_EN && (bus.rx_data == CH_A);
                    end
                end
                S_MATCH: begin
                    if (is_cr_s) begin
                        state_s = S_IDLE;
                        if (mask_r[0] && (pos_r == POS_OK_LEN)) begin
                            ev_s   = 1'b1;
                            code_s = CODE_OK;
                        end else if (mask_r[1] && (pos_r == POS_ERR_LEN)) begin
                            ev_s   = 1'b1;
                            code_s = CODE_ERR;
                        end else begin
                            ev_s   = 1'b0;
                        end
                    end else if (echo_r && (pos_r == POS_ONE) && (bus.rx_data == CH_T)) begin
                        state_s = S_DISCARD;
                    end else begin
                        echo_s = 1'b0;
                        mask_s = nmask_s;
                        if (nmask_s[2] && (pos_r == POS_TAG_LAST)) begin
                            ev_s    = 1'b1;
                            code_s  = CODE_CMPS;
                            state_s = S_DISCARD;
                        end else if (nmask_s[3] && (pos_r == POS_TAG_LAST)) begin
                            state_s = S_ARG;
                        end else if (nmask_s == 4'b0000) begin
                            state_s = S_DISCARD;
                        end else begin
                            state_s = S_MATCH;
                        end
                    end
                end
                S_ARG: begin
                    if (is_cr_s) begin
                        ev_s    = 1'b1;
                        code_s  = CODE_ERR;
                        state_s = S_IDLE;
                    end else if (!comma_r) begin
                        comma_s = (bus.rx_data == CH_COMMA);
                    end else if (is_dig_s) begin
                        idx_s   = bus.rx_data;
                        dig_s   = 8'd1;
                        state_s = S_IDX;
                    end else begin
                        ev_s    = 1'b1;
                        code_s  = CODE_ERR;
                        state_s = S_DISCARD;
                    end
                end
                S_IDX: begin
                    if (is_cr_s) begin
                        ev_s    = 1'b1;
                        code_s  = CODE_CMTI;
                        msg_s   = idx_r;
                        state_s = S_IDLE;
                    end else if (is_dig_s && (dig_cnt_r < IDX_MAX)) begin
                        idx_s = bus.rx_data;
                        dig_s = dig_cnt_r + 8'd1;
                    end else begin
                        ev_s    = 1'b1;
                        code_s  = CODE_ERR;
                        state_s = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_cr_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DISCARD;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase

            // Line length is tracked in every in-line state; overflow counts once per line
            if (state_r != S_IDLE) begin
                if (is_cr_s) begin
                    pos_s = POS_ZERO;
                end else if (pos_r < POS_MAX) begin
                    pos_s = pos_r + POS_ONE;
                    if ((pos_r + POS_ONE) == POS_MAX) begin
                        state_s   = S_DISCARD;
                        ovf_hit_s = !echo_s;
                    end else begin
                        ovf_hit_s = 1'b0;
                    end
                end else begin
                    pos_s = pos_r;
                end
            end else begin
                ovf_hit_s = 1'b0;
            end
        end else begin
            state_s = state_r;
        end

        if (ev_s) begin
            ctrl_s = code_s;
        end else if (bus.ctrl_rst) begin
            ctrl_s = CODE_NONE;
        end else begin
            ctrl_s = ctrl_r;
        end

        if (ovf_hit_s && (ovf_r != 8'hFF)) begin
            ovf_s = ovf_r + 8'd1;
        end else begin
            ovf_s = ovf_r;
        end

        busy_s = (state_s != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            pos_r     <= POS_ZERO;
            mask_r    <= 4'b0000;
            comma_r   <= 1'b0;
            idx_r     <= 8'h30;
            dig_cnt_r <= 8'd0;
            echo_r    <= 1'b0;
            ctrl_r    <= CODE_NONE;
            msg_no_r  <= 8'h30;
            busy_r    <= 1'b0;
            ovf_r     <= 8'd0;
        end else begin
            state_r   <= state_s;
            pos_r     <= pos_s;
            mask_r    <= mask_s;
            comma_r   <= comma_s;
            idx_r     <= idx_s;
            dig_cnt_r <= dig_s;
            echo_r    <= echo_s;
            ctrl_r    <= ctrl_s;
            msg_no_r  <= msg_s;
            busy_r    <= busy_s;
            ovf_r     <= ovf_s;
        end
    end

    assign bus.ctrl    = ctrl_r;
    assign bus.msg_no  = msg_no_r;
    assign bus.busy    = busy_r;
    assign bus.ovf_cnt = ovf_r;

endmodule

// File: tb/tb_at_resp_parser.sv
// Self-checking bench for at_resp_parser: directed table, corner sequences and
// random lines against a line-level reference model.
module tb_at_resp_parser;

    localparam int MAX_LINE   = 32;
    localparam int IDX_DIGITS = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    at_resp_parser_if bus ();

    at_resp_parser #(.MAX_LINE(MAX_LINE), .IDX_DIGITS(IDX_DIGITS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      line;
        logic [2:0] ctrl;
        logic [7:0] msg;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] line_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] m_ctrl;
    logic [7:0] m_msg;
    int         m_ovf;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] c, input logic [7:0] m,
                             input logic b, input int o);
        check({name, "_ctrl"}, 32'(bus.ctrl), 32'(c));
        check({name, "_msg"}, 32'(bus.msg_no), 32'(m));
        check({name, "_busy"}, 32'(bus.busy), 32'(b));
        check({name, "_ovf"}, 32'(bus.ovf_cnt), 32'(o));
    endtask

    task automatic put(input logic [7:0] b, input logic a);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.ctrl_rst = a;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.ctrl_rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        put(b, 1'b0);
        idle_cyc();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send(8'h0D);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.ctrl_rst = 1'b1;
        idle_cyc();
    endtask

    task automatic q_add(input string s);
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    endtask

    function automatic bit q_is(input string p, input bit exact);
        if (line_q.size() < p.len()) return 1'b0;
        if (exact && (line_q.size() != p.len())) return 1'b0;
        for (int i = 0; i < p.len(); i++) if (line_q[i] != p[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Line-level reference: event code, index digit and overflow of one complete line
    task automatic model_line(output logic [2:0] code, output logic [7:0] idx, output bit ovf);
        int  comma;
        int  n;
        bit  alldig;
        code  = 3'd0;
        idx   = 8'h00;
        ovf   = (line_q.size() >= MAX_LINE);
`ifdef AT_ECHO_FILTER_EN
        if (q_is("AT", 1'b0)) ovf = 1'b0;
`endif
        if (q_is("OK", 1'b1)) code = 3'd1;
        else if (q_is("ERROR", 1'b1)) code = 3'd3;
        else if (q_is("+CMPS:", 1'b0)) code = 3'd2;
        else if (q_is("+CMTI:", 1'b0)) begin
            code  = 3'd3;
            comma = -1;
            for (int i = 6; i < line_q.size(); i++)
                if ((comma < 0) && (line_q[i] == 8'h2C)) comma = i;
            if (comma >= 0) begin
                n      = line_q.size() - comma - 1;
                alldig = 1'b1;
                for (int i = comma + 1; i < line_q.size(); i++)
                    if ((line_q[i] < 8'h30) || (line_q[i] > 8'h39)) alldig = 1'b0;
                if (alldig && (n >= 1) && (n <= IDX_DIGITS)) begin
                    code = 3'd4;
                    idx  = line_q[line_q.size() - 1];
                end
            end
        end
    endtask

    initial begin
        string       pool;
        logic [2:0]  e_code;
        logic [7:0]  e_idx;
        bit          e_ovf;
        int          kind;
        int          echo_ovf;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.ctrl_rst = 1'b0;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 3'd0, 8'h30, 1'b0, 0);
        rst = 1'b1;

        // Basic OK line with leading CR/LF, busy window, and acknowledge
        send(8'h0D);
        send(8'h0A);
        check("crlf_busy", 32'(bus.busy), 32'd0);
        send(8'h4F);
        check("ok_busy_o", 32'(bus.busy), 32'd1);
        check("ok_ctrl_o", 32'(bus.ctrl), 32'd0);
        send(8'h4B);
        check("ok_busy_k", 32'(bus.busy), 32'd1);
        send(8'h0D);
        check_all("ok_done", 3'd1, 8'h30, 1'b0, 0);
        ack();
        check("ok_ack", 32'(bus.ctrl), 32'd0);

        // +CMPS: fires on the colon, trailing bytes change nothing
        send_str("+CMPS");
        check("cmps_pre", 32'(bus.ctrl), 32'd0);
        send(8'h3A);
        check("cmps_colon", 32'(bus.ctrl), 32'd2);
        send_str(" 10,30");
        check("cmps_tail", 32'(bus.ctrl), 32'd2);
        send(8'h0D);
        check_all("cmps_done", 3'd2, 8'h30, 1'b0, 0);

        // ERROR whose CR coincides with ctrl_rst: event wins
        send_str("ERROR");
        put(8'h0D, 1'b1);
        idle_cyc();
        check("err_vs_ack", 32'(bus.ctrl), 32'd3);
        ack();

        // 40-byte overflow, then normal parsing resumes
        for (int i = 0; i < 40; i++) send(8'h78);
        check_all("ovf40", 3'd0, 8'h30, 1'b1, 1);
        send(8'h0D);
        check("ovf40_cr_busy", 32'(bus.busy), 32'd0);
        send_line("OK");
        check("ovf_then_ok", 32'(bus.ctrl), 32'd1);
        ack();

        // Length boundary: one short of the limit, then exactly at it
        for (int i = 0; i < MAX_LINE - 1; i++) send(8'h78);
        send(8'h0D);
        check("len_max_m1", 32'(bus.ovf_cnt), 32'd1);
        for (int i = 0; i < MAX_LINE; i++) send(8'h78);
        send(8'h0D);
        check("len_max", 32'(bus.ovf_cnt), 32'd2);
        m_ovf = 2;

        vecs.push_back('{"OK", 3'd1, 8'h30});
        vecs.push_back('{"ERROR", 3'd3, 8'h30});
        vecs.push_back('{"OKAY", 3'd0, 8'h30});
        vecs.push_back('{"ok", 3'd0, 8'h30});
        vecs.push_back('{"ERR", 3'd0, 8'h30});
        vecs.push_back('{"ERRORX", 3'd0, 8'h30});
        vecs.push_back('{"+CMPS: 10,30", 3'd2, 8'h30});
        vecs.push_back('{"+CMTI: \"SM\",3", 3'd4, 8'h33});
        vecs.push_back('{"+CMTI: \"SM\",12", 3'd3, 8'h33});
        vecs.push_back('{"+CMTI: \"SM\",x", 3'd3, 8'h33});
        vecs.push_back('{"+CMTI: \"SM\"", 3'd3, 8'h33});
        vecs.push_back('{"+CMTI:,7", 3'd4, 8'h37});
        vecs.push_back('{"+CMTI: 5", 3'd3, 8'h37});
        vecs.push_back('{"AT+CMGD=1,4", 3'd0, 8'h37});
        vecs.push_back('{"+CMTI: \"ME\",0", 3'd4, 8'h30});
        vecs.push_back('{"+CMTI: \"SM\",9x", 3'd3, 8'h30});
        vecs.push_back('{"+CMPSX", 3'd0, 8'h30});
        vecs.push_back('{"OK\n", 3'd0, 8'h30});
        for (int i = 0; i < vecs.size(); i++) begin
            ack();
            send_line(vecs[i].line);
            check_all($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].msg, 1'b0, m_ovf);
        end

        // Long command echo: counted as overflow only without the echo filter
`ifdef AT_ECHO_FILTER_EN
        echo_ovf = m_ovf;
`else
        echo_ovf = m_ovf + 1;
`endif
        send_str("AT");
        for (int i = 0; i < 40; i++) send(8'h78);
        send(8'h0D);
        check_all("echo_long", 3'd0, 8'h30, 1'b0, echo_ovf);

        // Asynchronous reset in the middle of a line
        send_line("+CMTI:,5");
        check("pre_rst_ctrl", 32'(bus.ctrl), 32'd4);
        check("pre_rst_msg", 32'(bus.msg_no), 32'h35);
        send_str("+CM");
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1 check_all("mid_rst", 3'd0, 8'h30, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        send_line("OK");
        check_all("post_rst_ok", 3'd1, 8'h30, 1'b0, 0);
        m_ctrl = 3'd1;
        m_msg  = 8'h30;
        m_ovf  = 0;

        // Random lines against the line-level model
        pool = "xOK+CMPTIS:,0123456789 \"ERA";
        for (int n = 0; n < 150; n++) begin
            line_q.delete();
            kind = $urandom_range(0, 7);
            case (kind)
                0: q_add("OK");
                1: q_add("ERROR");
                2: begin
                    q_add("+CMPS: ");
                    repeat ($urandom_range(0, 3)) line_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                end
                3: begin
                    q_add("+CMTI: \"SM\",");
                    repeat ($urandom_range(0, 2)) line_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                    if ($urandom_range(0, 3) == 0) line_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
                end
                4: repeat ($urandom_range(1, 12)) line_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
                5: begin
                    q_add("+CMTI:");
                    repeat ($urandom_range(0, 6)) line_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
                end
                6: repeat ($urandom_range(28, 40)) line_q.push_back(8'h78);
                default: begin
                    if ($urandom_range(0, 1) == 1) q_add("OK");
                    else q_add("ERROR");
                    line_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                ack();
                m_ctrl = 3'd0;
                check($sformatf("rnd%0d_ack", n), 32'(bus.ctrl), 32'd0);
            end
            repeat ($urandom_range(0, 2)) send(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
            send(line_q[0]);
            check($sformatf("rnd%0d_busy", n), 32'(bus.busy), 32'd1);
            for (int i = 1; i < line_q.size(); i++) begin
                put(line_q[i], 1'b0);
                if ($urandom_range(0, 1) == 1) idle_cyc();
            end
            put(8'h0D, 1'b0);
            idle_cyc();
            model_line(e_code, e_idx, e_ovf);
            if (e_code != 3'd0) m_ctrl = e_code;
            if (e_code == 3'd4) m_msg = e_idx;
            if (e_ovf && (m_ovf < 255)) m_ovf++;
            check_all($sformatf("rnd%0d", n), m_ctrl, m_msg, 1'b0, m_ovf);
        end

        // Overflow counter saturation with back-to-back bytes
        for (int j = 0; j < 256; j++) begin
            for (int k = 0; k < MAX_LINE + 1; k++) put(8'h78, 1'b0);
            put(8'h0D, 1'b0);
        end
        idle_cyc();
        check_all("ovf_sat", m_ctrl, m_msg, 1'b0, 255);
        send_line("OK");
        check("sat_then_ok", 32'(bus.ctrl), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
